// File: rtl/text_pkg.sv
// rtl/text_pkg.sv - shared constants and state encoding for the text-mode renderer
package text_pkg;

  localparam int COLS        = 80;
  localparam int ROWS        = 60;
  localparam int SYMB_WIDTH  = 8;
  localparam int SYMB_HEIGHT = 8;
  localparam int DEPTH       = COLS * ROWS;
  localparam int IDX_W       = 13;
  localparam int COL_W       = 7;
  localparam int ROW_W       = 6;
  localparam int CHAR_W      = 7;

  localparam logic [CHAR_W-1:0] CLEAR_CHAR = 7'h20;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

endpackage

// File: rtl/text_renderer_if.sv
// rtl/text_renderer_if.sv - host write port into the character buffer
interface text_renderer_if;
  import text_pkg::*;

  logic              wr_valid;
  logic              wr_ready;
  logic [COL_W-1:0]  wr_col;
  logic [ROW_W-1:0]  wr_row;
  logic [CHAR_W-1:0] wr_char;

  modport master (
    output wr_valid, wr_col, wr_row, wr_char,
    input  wr_ready
  );

  modport slave (
    input  wr_valid, wr_col, wr_row, wr_char,
    output wr_ready
  );

endinterface

// File: rtl/text_buffer.sv
// rtl/text_buffer.sv - simple dual-port character RAM with registered, read-before-write read port
module text_buffer
  import text_pkg::*;
#(
  parameter int BUF_DEPTH = DEPTH,
  parameter int AW        = IDX_W,
  parameter int DW        = CHAR_W
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          we,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data
);

  logic [DW-1:0] mem [BUF_DEPTH];

  // Contents are deliberately left unreset so this maps onto block RAM.
  always_ff @(posedge clock) begin
    if (we) begin
      mem[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rd_data <= '0;
    end else begin
      rd_data <= rd_en ? mem[rd_addr] : '0;
    end
  end

endmodule

// File: rtl/text_renderer.sv
// rtl/text_renderer.sv - maps VGA counters to character codes and serializes font lines to pixels
module text_renderer
  import text_pkg::*;
#(
  parameter int                COLS       = text_pkg::COLS,
  parameter int                ROWS       = text_pkg::ROWS,
  parameter logic [CHAR_W-1:0] CLEAR_CHAR = text_pkg::CLEAR_CHAR
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [10:0]           pixel_x,
  input  logic [10:0]           pixel_y,
  input  logic                  video_on,
  output logic [CHAR_W-1:0]     symbol_address,
  input  logic [SYMB_WIDTH-1:0] symbol_line,
  output logic                  pixel_out,
  text_renderer_if.slave        wr,
  input  logic                  clear_start,
  output logic                  clear_busy
);

  localparam int              CELLS    = COLS * ROWS;
  localparam logic [0:0]      ST_IDLE  = IDLE;
  localparam logic [0:0]      ST_CLEAR = CLEAR;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(CELLS - 1);

  logic [0:0]       state;
  logic [IDX_W-1:0] clear_count;

  logic [COL_W-1:0] col;
  logic [ROW_W-1:0] row;
  logic             rd_in_range;
  logic [IDX_W-1:0] rd_index;

  logic             wr_in_range;
  logic [IDX_W-1:0] wr_index;

  logic              buf_we;
  logic [IDX_W-1:0]  buf_waddr;
  logic [CHAR_W-1:0] buf_wdata;

  logic [2:0] x_d1, x_d2;
  logic       von_d1, von_d2;
  logic       unused_bits;

  assign col = pixel_x[9:3];
  assign row = pixel_y[8:3];
  assign unused_bits = ^{pixel_x[10], pixel_y[10:9], pixel_y[2:0]};

  assign rd_in_range = (IDX_W'(col) < IDX_W'(COLS)) && (IDX_W'(row) < IDX_W'(ROWS));
  assign rd_index    = IDX_W'(row) * IDX_W'(COLS) + IDX_W'(col);

  assign wr_in_range = (IDX_W'(wr.wr_col) < IDX_W'(COLS)) && (IDX_W'(wr.wr_row) < IDX_W'(ROWS));
  assign wr_index    = IDX_W'(wr.wr_row) * IDX_W'(COLS) + IDX_W'(wr.wr_col);

  assign wr.wr_ready = (state == ST_IDLE);
  assign clear_busy  = (state == ST_CLEAR);

  // The clear sequence owns the write port; host writes only land in IDLE.
  always_comb begin
    buf_we    = 1'b0;
    buf_waddr = wr_index;
    buf_wdata = wr.wr_char;
    if (clear_busy) begin
      buf_we    = 1'b1;
      buf_waddr = clear_count;
      buf_wdata = CLEAR_CHAR;
    end else if (wr.wr_valid && wr.wr_ready && wr_in_range) begin
      buf_we = 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= ST_IDLE;
      clear_count <= '0;
    end else if (state == ST_IDLE) begin
      if (clear_start) begin
        state       <= ST_CLEAR;
        clear_count <= '0;
      end
    end else begin
      if (clear_count == LAST_IDX) begin
        state <= ST_IDLE;
      end else begin
        clear_count <= clear_count + 1'b1;
      end
    end
  end

  text_buffer #(
    .BUF_DEPTH (CELLS),
    .AW        (IDX_W),
    .DW        (CHAR_W)
  ) u_buffer (
    .clock   (clock),
    .reset   (reset),
    .we      (buf_we),
    .wr_addr (buf_waddr),
    .wr_data (buf_wdata),
    .rd_en   (rd_in_range),
    .rd_addr (rd_index),
    .rd_data (symbol_address)
  );

  // x and video_on ride two stages to meet the font line coming back from the ROM.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      x_d1      <= '0;
      x_d2      <= '0;
      von_d1    <= 1'b0;
      von_d2    <= 1'b0;
      pixel_out <= 1'b0;
    end else begin
      x_d1      <= pixel_x[2:0];
      x_d2      <= x_d1;
      von_d1    <= video_on;
      von_d2    <= von_d1;
      pixel_out <= von_d2 & symbol_line[3'd7 - x_d2];
    end
  end

endmodule

// File: tb/tb_text_renderer.sv
// tb/tb_text_renderer.sv - scoreboard bench for text_renderer
module tb_text_renderer;

  typedef struct { int x; int y; logic von; } pt_t;
  typedef struct { int due; logic [6:0] addr; int x; int y; } ea_t;
  typedef struct { int due; logic pix; int x; int y; } ep_t;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [10:0] pixel_x = '0;
  logic [10:0] pixel_y = '0;
  logic        video_on = 1'b0;
  logic [6:0]  symbol_address;
  logic [7:0]  symbol_line = '0;
  logic        pixel_out;
  logic        clear_start = 1'b0;
  logic        clear_busy;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [6:0] model [4800];
  pt_t pts[$];
  ea_t aq[$];
  ep_t pq[$];

  text_renderer_if wr_if ();

  text_renderer dut (
    .clock          (clock),
    .reset          (reset),
    .pixel_x        (pixel_x),
    .pixel_y        (pixel_y),
    .video_on       (video_on),
    .symbol_address (symbol_address),
    .symbol_line    (symbol_line),
    .pixel_out      (pixel_out),
    .wr             (wr_if),
    .clear_start    (clear_start),
    .clear_busy     (clear_busy)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  function automatic logic [7:0] font(input logic [6:0] c);
    return (c == 7'h41) ? 8'h81 : {c, ~c[0]};
  endfunction

  // Registered font ROM: one cycle from address to line.
  always @(posedge clock) symbol_line <= font(symbol_address);

  function automatic logic [6:0] exp_addr(input int x, input int y);
    int c, r;
    c = (x >> 3) & 127;
    r = (y >> 3) & 63;
    if (c >= 80 || r >= 60) return 7'h00;
    return model[r * 80 + c];
  endfunction

  task automatic add_pt(input int x, input int y, input logic von);
    pt_t p;
    p.x = x; p.y = y; p.von = von;
    pts.push_back(p);
  endtask

  task automatic run_scan(input string name);
    pt_t p;
    ea_t ea;
    ep_t ep;
    logic [7:0] fl;
    int guard;
    guard = 0;
    while ((pts.size() > 0 || aq.size() > 0 || pq.size() > 0) && guard < 20000) begin
      if (aq.size() > 0 && aq[0].due <= cyc) begin
        ea = aq.pop_front();
        total++;
        if (symbol_address !== ea.addr) begin
          bad++;
          $display("FAIL %s addr x=%0d y=%0d got=%h exp=%h", name, ea.x, ea.y, symbol_address, ea.addr);
        end
      end
      if (pq.size() > 0 && pq[0].due <= cyc) begin
        ep = pq.pop_front();
        total++;
        if (pixel_out !== ep.pix) begin
          bad++;
          $display("FAIL %s pixel x=%0d y=%0d got=%b exp=%b", name, ep.x, ep.y, pixel_out, ep.pix);
        end
      end
      if (pts.size() > 0) begin
        p = pts.pop_front();
        pixel_x  = 11'(p.x);
        pixel_y  = 11'(p.y);
        video_on = p.von;
        ea.due = cyc + 1; ea.addr = exp_addr(p.x, p.y); ea.x = p.x; ea.y = p.y;
        aq.push_back(ea);
        fl = font(ea.addr);
        ep.due = cyc + 3; ep.pix = p.von & fl[7 - (p.x & 7)]; ep.x = p.x; ep.y = p.y;
        pq.push_back(ep);
      end else begin
        video_on = 1'b0;
      end
      @(negedge clock);
      guard++;
    end
    if (guard >= 20000) begin
      total++; bad++;
      $display("FAIL %s scan timeout got=%0d pending exp=0", name, aq.size() + pq.size());
      pts.delete(); aq.delete(); pq.delete();
    end
  endtask

  task automatic host_write(input int c, input int r, input logic [6:0] ch);
    wr_if.wr_valid = 1'b1;
    wr_if.wr_col   = 7'(c);
    wr_if.wr_row   = 6'(r);
    wr_if.wr_char  = ch;
    total++;
    if (wr_if.wr_ready !== 1'b1) begin
      bad++;
      $display("FAIL write_ready got=%b exp=1", wr_if.wr_ready);
    end
    @(negedge clock);
    wr_if.wr_valid = 1'b0;
    if (c < 80 && r < 60) model[r * 80 + c] = ch;
  endtask

  task automatic wait_clear_done(input string name);
    int n;
    n = 0;
    while (clear_busy === 1'b1 && n < 6000) begin
      @(negedge clock);
      n++;
    end
    total++;
    if (clear_busy !== 1'b0) begin
      bad++;
      $display("FAIL %s clear_timeout got=%b exp=0", name, clear_busy);
    end
    for (int i = 0; i < 4800; i++) model[i] = 7'h20;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      pixel_x     = 11'($urandom);
      pixel_y     = 11'($urandom);
      video_on    = 1'($urandom);
      clear_start = 1'($urandom);
      #1;
      total += 3;
      if (pixel_out !== 1'b0) begin bad++; $display("FAIL reset pixel_out got=%b exp=0", pixel_out); end
      if (symbol_address !== 7'h00) begin bad++; $display("FAIL reset symbol_address got=%h exp=00", symbol_address); end
      if (clear_busy !== 1'b0) begin bad++; $display("FAIL reset clear_busy got=%b exp=0", clear_busy); end
    end
    @(negedge clock);
    clear_start = 1'b0;
    reset = 1'b1;
    @(negedge clock);
    total += 2;
    if (wr_if.wr_ready !== 1'b1) begin bad++; $display("FAIL reset wr_ready got=%b exp=1", wr_if.wr_ready); end
    if (clear_busy !== 1'b0) begin bad++; $display("FAIL reset post_release clear_busy got=%b exp=0", clear_busy); end
  endtask

  task automatic test_single_glyph();
    host_write(2, 1, 7'h41);
    for (int x = 16; x <= 23; x++) add_pt(x, 8, 1'b1);
    run_scan("glyph");
  endtask

  task automatic test_clear();
    int busy_cnt, rdy_bad;
    clear_start = 1'b1;
    @(negedge clock);
    clear_start = 1'b0;
    busy_cnt = 0;
    rdy_bad = 0;
    while (clear_busy === 1'b1 && busy_cnt < 6000) begin
      busy_cnt++;
      if (wr_if.wr_ready !== 1'b0) rdy_bad++;
      wr_if.wr_valid = (busy_cnt == 4790);
      wr_if.wr_col = 7'd0; wr_if.wr_row = 6'd0; wr_if.wr_char = 7'h11;
      @(negedge clock);
    end
    wr_if.wr_valid = 1'b0;
    total += 2;
    if (busy_cnt != 4800) begin bad++; $display("FAIL clear busy_cycles got=%0d exp=4800", busy_cnt); end
    if (rdy_bad != 0) begin bad++; $display("FAIL clear wr_ready_high_cycles got=%0d exp=0", rdy_bad); end
    wait_clear_done("clear");
    for (int r = 0; r < 60; r++)
      for (int c = 0; c < 80; c++)
        add_pt(c * 8 + (c % 8), r * 8 + (r % 8), 1'b1);
    run_scan("clear_frame");
  endtask

  task automatic test_bounds();
    host_write(80, 0, 7'h7F);
    host_write(0, 60, 7'h7E);
    add_pt(0, 8, 1'b1);
    add_pt(632, 472, 1'b1);
    add_pt(700, 8, 1'b1);
    add_pt(16, 480, 1'b1);
    add_pt(16, 8, 1'b0);
    add_pt(23, 8, 1'b0);
    run_scan("bounds");
  endtask

  task automatic test_collision();
    wr_if.wr_valid = 1'b1;
    wr_if.wr_col = 7'd0; wr_if.wr_row = 6'd0; wr_if.wr_char = 7'h55;
    clear_start = 1'b1;
    total++;
    if (wr_if.wr_ready !== 1'b1) begin bad++; $display("FAIL collision wr_ready got=%b exp=1", wr_if.wr_ready); end
    @(negedge clock);
    wr_if.wr_valid = 1'b0;
    clear_start = 1'b0;
    total++;
    if (clear_busy !== 1'b1) begin bad++; $display("FAIL collision clear_busy got=%b exp=1", clear_busy); end
    wait_clear_done("collision");
    add_pt(0, 0, 1'b1);
    add_pt(7, 0, 1'b1);
    run_scan("collision");
  endtask

  task automatic test_abort();
    int rdy_bad, busy_bad;
    rdy_bad = 0;
    for (int i = 0; i < 106; i++) begin
      wr_if.wr_valid = 1'b1;
      wr_if.wr_col = 7'(i % 80); wr_if.wr_row = 6'(i / 80); wr_if.wr_char = 7'h33;
      if (wr_if.wr_ready !== 1'b1) rdy_bad++;
      @(negedge clock);
      model[i] = 7'h33;
    end
    wr_if.wr_valid = 1'b0;
    total++;
    if (rdy_bad != 0) begin bad++; $display("FAIL back_to_back wr_ready_low got=%0d exp=0", rdy_bad); end
    for (int i = 0; i < 106; i++) add_pt((i % 80) * 8 + (i % 8), (i / 80) * 8, 1'b1);
    run_scan("back_to_back");

    clear_start = 1'b1;
    @(negedge clock);
    clear_start = 1'b0;
    busy_bad = 0;
    for (int i = 0; i < 100; i++) begin
      if (clear_busy !== 1'b1) busy_bad++;
      @(negedge clock);
    end
    reset = 1'b0;
    #1;
    total += 4;
    if (busy_bad != 0) begin bad++; $display("FAIL abort busy_low_cycles got=%0d exp=0", busy_bad); end
    if (clear_busy !== 1'b0) begin bad++; $display("FAIL abort clear_busy got=%b exp=0", clear_busy); end
    if (symbol_address !== 7'h00) begin bad++; $display("FAIL abort symbol_address got=%h exp=00", symbol_address); end
    if (pixel_out !== 1'b0) begin bad++; $display("FAIL abort pixel_out got=%b exp=0", pixel_out); end
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    total++;
    if (wr_if.wr_ready !== 1'b1) begin bad++; $display("FAIL abort wr_ready got=%b exp=1", wr_if.wr_ready); end
    for (int i = 0; i < 100; i++) model[i] = 7'h20;
    for (int i = 0; i < 106; i++) add_pt((i % 80) * 8 + (i % 8), (i / 80) * 8 + 3, 1'b1);
    run_scan("abort");
  endtask

  initial begin
    wr_if.wr_valid = 1'b0;
    wr_if.wr_col   = '0;
    wr_if.wr_row   = '0;
    wr_if.wr_char  = '0;
    test_reset();
    test_single_glyph();
    test_clear();
    test_bounds();
    test_collision();
    test_abort();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/text_renderer.md
# text_renderer

Text-mode pixel generator that drives the font ROM's `symbol_address` input and consumes its `symbol_line` output. It holds a writable 80×60 character buffer and maps the VGA timing counters `pixel_x`/`pixel_y` to a character code. It serializes the returned 8-pixel font line into a 1-bit pixel stream, and sits between the VGA sync generator, the font memory, and a host write port.

## Interface

Parameters:
- `COLS`, 80, text columns (640 / 8)
- `ROWS`, 60, text rows (480 / 8)
- `CLEAR_CHAR`, 7'h20, code written by the clear sequence

Ports:
- `clock`  in  1  pixel clock; the only clock
- `reset`  in  1  asynchronous, active-low reset
- `pixel_x`  in  11  current horizontal pixel counter
- `pixel_y`  in  11  current vertical pixel counter
- `video_on`  in  1  active-area flag aligned with `pixel_x`/`pixel_y`
- `symbol_address`  out  7  character code to the font memory, registered
- `symbol_line`  in  8  font line from the font memory; MSB is the leftmost pixel
- `pixel_out`  out  1  serialized pixel, registered
- `wr_valid`  in  1  host write request
- `wr_ready`  out  1  write port can accept
- `wr_col`  in  7  target column
- `wr_row`  in  6  target row
- `wr_char`  in  7  character code to store
- `clear_start`  in  1  single-cycle request to fill the buffer with `CLEAR_CHAR`
- `clear_busy`  out  1  clear sequence in progress

## Operation

- **Read path**
  - `col = pixel_x[9:3]`, `row = pixel_y[8:3]`.
  - Buffer index = `row*COLS + col`, 13 bits; computed as `(row<<6)+(row<<4)+col` for `COLS`=80.
  - If `col >= COLS` or `row >= ROWS`, `symbol_address` is forced to 0.
- **Font lookup**: the font memory selects the glyph line using its own `pixel_y[2:0]`. `pixel_y` is constant across a line, so no y delay is needed.
- **Serialization**
  - `pixel_x[2:0]` and `video_on` are delayed 2 cycles.
  - `pixel_out <= video_on_d2 & symbol_line[7 - x_d2[2:0]]`.
- **Write port**
  - `wr_ready = (state == IDLE)`.
  - A transfer occurs on any edge where `wr_valid && wr_ready`; the cell is updated at that edge.
  - Out-of-range `wr_col`/`wr_row` are accepted and discarded; no cell changes.
- **State machine**
  - IDLE: `clear_start` → CLEAR, clear counter = 0.
  - CLEAR: writes `CLEAR_CHAR` to index `counter`, one cell per cycle. Counter increments. At index `COLS*ROWS-1` the machine returns to IDLE.
  - `clear_busy = (state == CLEAR)`.
  - `clear_start` while in CLEAR is ignored.
- **Simultaneous events**
  - `wr_valid` and `clear_start` in the same IDLE cycle: the write is accepted, and CLEAR starts next cycle, overwriting it.
  - Reading a cell on the same edge it is written returns the old value (read-before-write).
- **Reset** (asserted, async): state IDLE, counter 0, `symbol_address` 0, `pixel_out` 0, delay registers 0, `clear_busy` 0, `wr_ready` 1 after release.
  - Buffer contents are not reset; power-up contents are unspecified.
  - Reset mid-clear aborts the sequence; already-written cells keep `CLEAR_CHAR`.

## Timing

- Pixel presented in cycle N:
  - `symbol_address` valid in N+1
  - font `symbol_line` valid in N+2
  - `pixel_out` valid in N+3
- Total latency is 3 clocks. The top level delays hsync/vsync by 3 clocks to match.
- Clear takes exactly `COLS*ROWS` = 4800 cycles of `clear_busy` high.
- Host writes sustain one per cycle when `wr_ready` is high.

## Structure

- **Package `text_pkg`**: `COLS`, `ROWS`, `SYMB_WIDTH`=8, `SYMB_HEIGHT`=8, `CLEAR_CHAR`, buffer depth/index width constants, and the `state_t` enum {IDLE, CLEAR}.
- **Sub-module `text_buffer`**: simple dual-port RAM, 4800×7.
  - One write port, fed by the write-port/clear mux.
  - One registered read port whose output is `symbol_address`.
  - Read-before-write behaviour.

## Test plan

- **Reset**: hold `reset`=0 with random inputs → `pixel_out`=0, `symbol_address`=0, `clear_busy`=0; `wr_ready`=1 after release.
- **Single glyph**: write 7'h41 at col 2, row 1; font model returns 8'b1000_0001; scan `pixel_y`=8, `pixel_x`=16..23 with `video_on`=1 → `symbol_address`=7'h41 one cycle after x=16. `pixel_out`=1 exactly 3 cycles after x=16 and after x=23, and 0 for x=17..22.
- **Clear**: pulse `clear_start` → `clear_busy` high for exactly 4800 cycles and `wr_ready` low throughout. A `wr_valid` in this window is not accepted. Afterwards a full-frame scan shows `symbol_address`=7'h20 for every cell.
- **Collision**: `wr_valid` (col 0, row 0, 7'h55) and `clear_start` in the same IDLE cycle → write accepted; after the clear, cell (0,0) reads 7'h20.
- **Bounds**: write with `wr_col`=80 → accepted, no cell changes. Scan `pixel_x`=700 → `symbol_address`=0. `video_on`=0 → `pixel_out`=0.
- **Abort**: assert `reset` at clear cycle 100 → `clear_busy`=0 immediately; after release, cells 0..99 read 7'h20 and cell 100 retains its prior value.
